alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 27 ++
 rtl/alu_arbiter.sv | 88 ++++++++
 tb/tb_alu_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response and shared-ALU bus of the two-requester ALU arbiter.
// The arbiter connects through the slave modport and the environment through the master modport.
interface alu_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid, req1_valid;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]        req0_op, req1_op;
  logic              req0_ready, req1_ready;
  logic              rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp0_data, rsp1_data;
  logic [DATA_W-1:0] EntradaA, EntradaB;
  logic [1:0]        OP;
  logic [DATA_W-1:0] Saida;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op, Saida,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
           EntradaA, EntradaB, OP
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op, Saida,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
           EntradaA, EntradaB, OP
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: IDLE grants, EXEC captures Saida,
// RESP pulses the result back; one operation in flight, round-robin on contention.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              grant_q, grant_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              grant_sel;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d        = state_q;
    prio_d         = prio_q;
    grant_d        = grant_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    result_d       = result_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    // A lone requester wins outright; the pointer only breaks ties.
    grant_sel = (bus.req0_valid && bus.req1_valid) ? prio_q : !bus.req0_valid;

    case (state_q)
      IDLE: begin
        if (!rst && (bus.req0_valid || bus.req1_valid)) begin
          bus.req0_ready = !grant_sel;
          bus.req1_ready = grant_sel;
          grant_d        = grant_sel;
          a_d            = grant_sel ? bus.req1_a  : bus.req0_a;
          b_d            = grant_sel ? bus.req1_b  : bus.req0_b;
          op_d           = grant_sel ? bus.req1_op : bus.req0_op;
          state_d        = EXEC;
        end
      end
      EXEC: begin
        result_d = bus.Saida;
        state_d  = RESP;
      end
      RESP: begin
        bus.rsp0_valid = !rst && !grant_q;
        bus.rsp1_valid = !rst && grant_q;
        prio_d         = !grant_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.EntradaA  = a_q;
  assign bus.EntradaB  = b_q;
  assign bus.OP        = op_q;
  assign bus.rsp0_data = result_q;
  assign bus.rsp1_data = result_q;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      grant_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 2'b00;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      grant_q  <= grant_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a cycle-scheduled transaction model
// (free-at cycle, pending-response queue) and a reference ALU driving Saida.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;

  alu_arbiter_if bus ();
  alu_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign bus.Saida = alu_ref(bus.EntradaA, bus.EntradaB, bus.OP);

  typedef struct {
    int          due;
    logic        id;
    logic [31:0] data;
  } rsp_t;

  rsp_t        pend[$];
  int          cyc, free_cyc, n_vec, n_err;
  logic        prio_m;
  logic [31:0] res_m, ent_a, ent_b;
  logic [1:0]  ent_op;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [1:0] o0, input logic v1, input logic [31:0] a1,
                      input logic [31:0] b1, input logic [1:0] o1, input logic r);
    logic acc, gid, ev0, ev1;
    rst = r;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = o0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = o1;
    @(negedge clk);
    acc = !r && (cyc >= free_cyc) && (v0 || v1);
    gid = (v0 && v1) ? prio_m : !v0;
    ev0 = !r && pend.size() > 0 && pend[0].due == cyc && pend[0].id == 1'b0;
    ev1 = !r && pend.size() > 0 && pend[0].due == cyc && pend[0].id == 1'b1;
    check("req0_ready", 32'(bus.req0_ready), 32'(acc && !gid));
    check("req1_ready", 32'(bus.req1_ready), 32'(acc && gid));
    check("rsp0_valid", 32'(bus.rsp0_valid), 32'(ev0));
    check("rsp1_valid", 32'(bus.rsp1_valid), 32'(ev1));
    if (ev0) check("rsp0_data_txn", bus.rsp0_data, pend[0].data);
    if (ev1) check("rsp1_data_txn", bus.rsp1_data, pend[0].data);
    check("rsp0_data_held", bus.rsp0_data, res_m);
    check("rsp1_data_held", bus.rsp1_data, res_m);
    check("EntradaA", bus.EntradaA, ent_a);
    check("EntradaB", bus.EntradaB, ent_b);
    check("OP", 32'(bus.OP), 32'(ent_op));
    @(posedge clk);
    #1;
    if (r) begin
      free_cyc = cyc + 1;
      prio_m   = 1'b0;
      pend.delete();
      res_m = '0; ent_a = '0; ent_b = '0; ent_op = 2'b00;
    end else begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
        prio_m = !pend[0].id;
        void'(pend.pop_front());
      end else if (pend.size() > 0 && pend[0].due == cyc + 1) begin
        res_m = pend[0].data;
      end
      if (acc) begin
        ent_a  = gid ? a1 : a0;
        ent_b  = gid ? b1 : b0;
        ent_op = gid ? o1 : o0;
        pend.push_back('{due: cyc + 2, id: gid, data: alu_ref(ent_a, ent_b, ent_op)});
        free_cyc = cyc + 3;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 2'b00, 1'b0, '0, '0, 2'b00, r);
  endtask

  initial begin
    logic [31:0] ra0, rb0, ra1, rb1;
    logic [1:0]  ro0, ro1;
    logic        rv0, rv1, rr;
    n_vec = 0; n_err = 0; cyc = 0; free_cyc = 0; prio_m = 1'b0;
    res_m = '0; ent_a = '0; ent_b = '0; ent_op = 2'b00;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 2'b00;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    idle(1, 1'b1);
    idle(1, 1'b0);

    // single op from requester 0
    step(1'b1, 32'd2001, 32'd4001, 2'b00, 1'b0, '0, '0, 2'b00, 1'b0);
    idle(3, 1'b0);

    // opcode sweep from requester 1, back-to-back
    for (int op = 0; op < 4; op++) begin
      step(1'b0, '0, '0, 2'b00, 1'b1, 32'd2001, 32'd4001, 2'(op), 1'b0);
      idle(2, 1'b0);
    end
    idle(1, 1'b0);

    // wrap-around on requester 0
    for (int op = 0; op < 4; op++) begin
      step(1'b1, 32'hFFFF_FFFF, 32'd1, 2'(op), 1'b0, '0, '0, 2'b00, 1'b0);
      idle(2, 1'b0);
    end

    // reset, then continuous contention with random operands
    idle(1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      ra0 = $urandom; rb0 = $urandom; ro0 = 2'($urandom_range(3));
      ra1 = $urandom; rb1 = $urandom; ro1 = 2'($urandom_range(3));
      step(1'b1, ra0, rb0, ro0, 1'b1, ra1, rb1, ro1, 1'b0);
    end
    idle(3, 1'b0);

    // reset in EXEC after a completed op left the pointer at 1
    step(1'b1, 32'd7, 32'd9, 2'b01, 1'b0, '0, '0, 2'b00, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 32'd11, 32'd13, 2'b00, 1'b0, '0, '0, 2'b00, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    step(1'b1, 32'd21, 32'd22, 2'b00, 1'b1, 32'd31, 32'd32, 2'b10, 1'b0);
    idle(3, 1'b0);

    // requester 1 holds valid through EXEC/RESP
    for (int i = 0; i < 9; i++) step(1'b0, '0, '0, 2'b00, 1'b1, 32'(100 + i), 32'd3, 2'b01, 1'b0);
    idle(3, 1'b0);

    // fully random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rv0 = ($urandom_range(3) != 0); rv1 = ($urandom_range(2) != 0);
      rr  = ($urandom_range(39) == 0);
      ra0 = $urandom; rb0 = $urandom; ro0 = 2'($urandom_range(3));
      ra1 = $urandom; rb1 = $urandom; ro1 = 2'($urandom_range(3));
      step(rv0, ra0, rb0, ro0, rv1, ra1, rb1, ro1, rr);
    end
    idle(3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
